serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 19 +
 rtl/serial_fa_cell.sv | 17 +
 rtl/serial_adder.sv | 122 ++++++++++++
 tb/tb_serial_adder.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM states, default width, counter sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_adder_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-counter width: ceil(log2(w)), never narrower than one bit.
    function automatic int cnt_bits(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder used as the serial adder's per-cycle step.
// Latency: combinational.
// Backpressure: none (pure function of inputs).
//
// Ports: a, b, cin -> sum, cout
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (b & cin) | (a & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: accepts A, B, cin and produces A+B+cin one bit per cycle, LSB first.
// Latency: WIDTH RUN cycles after the accepting edge; result visible on the following cycle.
// Backpressure: input accepted only in IDLE; result held in DONE until io_out_ready.
//
// Ports: clock, reset (sync, active-low); io_in_{valid,ready,a,b,cin} operand handshake;
//        io_out_{valid,ready,sum,cout} result handshake.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_a,
    input  logic [WIDTH-1:0] io_in_b,
    input  logic             io_in_cin,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out_sum,
    output logic             io_out_cout
);

    localparam int                CW   = cnt_bits(WIDTH);
    localparam logic [CW-1:0]     LAST = CW'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic [CW-1:0]    cnt_q;

    logic             fa_sum;
    logic             fa_cout;
    logic             last_step;

    serial_fa_cell u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last_step = (state_q == RUN) && (cnt_q == LAST);

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. DONE never accepts new operands, even on the
    // handshake edge; the accept happens from IDLE on a later edge.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (io_in_valid)  state_d = RUN;
            RUN:     if (last_step)    state_d = DONE;
            DONE:    if (io_out_ready) state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    // Handshake outputs.
    always_comb begin
        io_in_ready  = (state_q == IDLE);
        io_out_valid = (state_q == DONE);
    end

    // Datapath. Sum bits enter at the MSB and shift down, so after WIDTH
    // steps the first-computed bit sits at the LSB. The counter holds on the
    // final step rather than rolling past WIDTH-1.
    always_ff @(posedge clock) begin
        if (!reset) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (io_in_valid) begin
                        a_q     <= io_in_a;
                        b_q     <= io_in_b;
                        carry_q <= io_in_cin;
                        cnt_q   <= '0;
                        sum_q   <= '0;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    sum_q   <= {fa_sum, sum_q[WIDTH-1:1]};
                    carry_q <= fa_cout;
                    if (last_step) begin
                        cout_q <= fa_cout;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers stay put through DONE and IDLE until the next accept.
    assign io_out_sum  = sum_q;
    assign io_out_cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_cout;

    int n_checks  = 0;
    int n_errors  = 0;
    int n_results = 0;
    int exp_results = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (in_valid),
        .io_in_ready  (in_ready),
        .io_in_a      (in_a),
        .io_in_b      (in_b),
        .io_in_cin    (in_cin),
        .io_out_valid (out_valid),
        .io_out_ready (out_ready),
        .io_out_sum   (out_sum),
        .io_out_cout  (out_cout)
    );

    always #5 clock = ~clock;

    // Count completed result handshakes, sampled away from the active edge.
    always @(negedge clock) begin
        if (reset && out_valid && out_ready) n_results++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One full transaction. Reference result is plain arithmetic on the operands.
    // noisy=1 keeps io_in_valid high and scrambles operands after the accept.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input int hold, input bit noisy);
        logic [W:0] ref_v;
        int         lat;
        int         waitc;
        ref_v = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

        waitc = 0;
        while (!in_ready && waitc < 50) begin
            tick();
            waitc++;
        end
        check("in_ready_before_accept", in_ready, 1);

        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        tick();
        lat = 1;
        while (!out_valid && lat < 100) begin
            if (noisy) begin
                in_a   = W'($urandom);
                in_b   = W'($urandom);
                in_cin = 1'($urandom_range(1, 0));
            end else begin
                in_valid = 1'b0;
            end
            tick();
            lat++;
        end
        // Edges counted inclusive of the accepting edge up to the first DONE cycle.
        check("latency", lat, W + 1);
        check("sum", out_sum, ref_v[W-1:0]);
        check("cout", out_cout, ref_v[W]);
        check("in_ready_done", in_ready, 0);

        for (int i = 0; i < hold; i++) begin
            if (noisy) begin
                in_a = W'($urandom);
                in_b = W'($urandom);
            end
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_sum", out_sum, ref_v[W-1:0]);
            check("hold_cout", out_cout, ref_v[W]);
        end

        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        exp_results++;
        check("idle_after_handshake_valid", out_valid, 0);
        check("idle_after_handshake_ready", in_ready, 1);
        check("retained_sum", out_sum, ref_v[W-1:0]);
        check("retained_cout", out_cout, ref_v[W]);
        check("result_count", n_results, exp_results);
        in_valid = 1'b0;
    endtask

    initial begin
        bit saw_valid;

        // Reset state.
        reset = 1'b0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", out_sum, 0);
        check("rst_cout", out_cout, 0);
        reset = 1'b1;
        tick();
        check("idle_hold_valid", out_valid, 0);

        // Directed cases.
        run_op(8'h5A, 8'h33, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'h00, 1'b1, 0, 1'b0);
        run_op(8'hC3, 8'h7E, 1'b1, 5, 1'b0);

        // Reset during the third RUN cycle discards the operation.
        in_valid = 1'b1;
        in_a = 8'hAB;
        in_b = 8'hCD;
        in_cin = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        in_valid = 1'b1;
        in_a = 8'h77;
        in_b = 8'h11;
        tick();
        check("rst_mid_in_ready", in_ready, 1);
        check("rst_mid_valid", out_valid, 0);
        reset = 1'b1;
        in_valid = 1'b0;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_sum", out_sum, 0);
        saw_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) saw_valid = 1'b1;
        end
        check("post_rst_no_result", saw_valid, 0);
        check("post_rst_result_count", n_results, exp_results);
        run_op(8'h10, 8'h20, 1'b0, 0, 1'b0);

        // Input noise during RUN/DONE, then back-to-back operations.
        run_op(8'h01, 8'h01, 1'b0, 2, 1'b1);
        run_op(8'h80, 8'h80, 1'b0, 0, 1'b1);

        // Randomised transactions.
        for (int k = 0; k < 20; k++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom_range(1, 0)),
                   int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
